// File: rtl/ctrl_banco_reg.sv
// ctrl_banco_reg
//   Access sequencer in front of the 4x8 register bank (BR). It takes read and
//   write commands over a valid/ready handshake and strobes the bank's
//   En/WE/Dir/Dato_e inputs for exactly one cycle per command. For reads it
//   captures the bank data and returns it over a valid/ready response channel.
//   The bank has no reset, so after reset the controller can optionally sweep
//   zeros into every address.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   cmd_valid/ready  command handshake; cmd_we (1=write), cmd_dir, cmd_dato
//   resp_valid/ready read response handshake; resp_dato
//   br_en, br_we,    bank strobes; br_dir/br_dato_e keep their last driven
//   br_dir,          value while br_en=0
//   br_dato_e
//   br_dato_s        bank read data, valid the cycle after a read strobe
//   ocupado          high whenever the controller is not idle
//   cnt_esc          command writes issued to the bank (sweep not counted), wraps
//   cnt_lec          reads completed on the response handshake, wraps
module ctrl_banco_reg #(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 2,
    parameter int CNT_W        = 8,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_dir,
    input  logic [DATA_W-1:0] cmd_dato,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_dato,
    output logic              br_en,
    output logic              br_we,
    output logic [ADDR_W-1:0] br_dir,
    output logic [DATA_W-1:0] br_dato_e,
    input  logic [DATA_W-1:0] br_dato_s,
    output logic              ocupado,
    output logic [CNT_W-1:0]  cnt_esc,
    output logic [CNT_W-1:0]  cnt_lec
);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_RESP
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_DIR = '1;

    state_t            r_state;
    logic [ADDR_W-1:0] r_idx;
    logic              r_we;
    logic [ADDR_W-1:0] r_br_dir;
    logic [DATA_W-1:0] r_br_dato_e;
    logic [DATA_W-1:0] r_resp_dato;
    logic [CNT_W-1:0]  r_cnt_esc;
    logic [CNT_W-1:0]  r_cnt_lec;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= (CLEAR_ON_RST != 0) ? S_CLEAR : S_IDLE;
            r_idx       <= '0;
            r_we        <= 1'b0;
            r_br_dir    <= '0;
            r_br_dato_e <= '0;
            r_resp_dato <= '0;
            r_cnt_esc   <= '0;
            r_cnt_lec   <= '0;
        end else begin
            case (r_state)
                // br_dir register doubles as the visible sweep address, so it
                // is advanced together with the index and simply left at the
                // last address when the sweep ends.
                S_CLEAR: begin
                    if (r_idx == LAST_DIR) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_idx    <= r_idx + 1'b1;
                        r_br_dir <= r_idx + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_we        <= cmd_we;
                        r_br_dir    <= cmd_dir;
                        r_br_dato_e <= cmd_dato;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_we) begin
                        r_cnt_esc <= r_cnt_esc + 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    r_resp_dato <= br_dato_s;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_cnt_lec <= r_cnt_lec + 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready  = (r_state == S_IDLE);
    assign ocupado    = (r_state != S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign resp_dato  = r_resp_dato;
    assign br_en      = (r_state == S_CLEAR) || (r_state == S_ISSUE);
    assign br_we      = (r_state == S_CLEAR) || ((r_state == S_ISSUE) && r_we);
    assign br_dir     = r_br_dir;
    assign br_dato_e  = r_br_dato_e;
    assign cnt_esc    = r_cnt_esc;
    assign cnt_lec    = r_cnt_lec;

endmodule

// File: tb/tb_ctrl_banco_reg.sv
module tb_ctrl_banco_reg;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int CW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_dir;
    logic [DW-1:0] cmd_dato;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_dato;
    logic          br_en;
    logic          br_we;
    logic [AW-1:0] br_dir;
    logic [DW-1:0] br_dato_e;
    logic [DW-1:0] br_dato_s = '0;
    logic          ocupado;
    logic [CW-1:0] cnt_esc;
    logic [CW-1:0] cnt_lec;

    always #5 clk = ~clk;

    ctrl_banco_reg #(
        .DATA_W(DW),
        .ADDR_W(AW),
        .CNT_W(CW),
        .CLEAR_ON_RST(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we(cmd_we),
        .cmd_dir(cmd_dir),
        .cmd_dato(cmd_dato),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_dato(resp_dato),
        .br_en(br_en),
        .br_we(br_we),
        .br_dir(br_dir),
        .br_dato_e(br_dato_e),
        .br_dato_s(br_dato_s),
        .ocupado(ocupado),
        .cnt_esc(cnt_esc),
        .cnt_lec(cnt_lec)
    );

    // Register bank: no reset, nonzero power-up contents so the sweep matters.
    logic [DW-1:0] bank [DEPTH] = '{8'h3C, 8'hC3, 8'h99, 8'h66};
    always @(posedge clk) begin
        if (br_en) begin
            if (br_we) bank[br_dir] <= br_dato_e;
            else       br_dato_s    <= bank[br_dir];
        end
    end

    // Reference model and scoreboard
    int            n_vec = 0;
    int            n_err = 0;
    int            exp_esc;
    int            exp_lec;
    logic [DW-1:0] ref_mem [DEPTH];
    logic [AW+DW:0] strb_q [$];   // {we, dir, data} of each expected bank strobe
    logic [DW-1:0]  resp_q [$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: got timeout/unexpected event, expected none at %0t", nm, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every bank strobe and every response handshake.
    always @(negedge clk) begin
        if (!rst) begin
            check("busy_vs_ready", {31'd0, ocupado}, {31'd0, ~cmd_ready});
            if (br_en) begin
                if (strb_q.size() == 0) fail("unexpected_strobe");
                else check("strobe", {21'd0, br_we, br_dir, br_dato_e}, {21'd0, strb_q.pop_front()});
            end
            if (resp_valid && resp_ready) begin
                if (resp_q.size() == 0) fail("unexpected_resp");
                else check("resp_dato", {24'd0, resp_dato}, {24'd0, resp_q.pop_front()});
                exp_lec++;
            end
        end
    end

    task automatic do_reset();
        int n;
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        resp_ready = 1'b0;
        tick();
        strb_q.delete();
        resp_q.delete();
        exp_esc = 0;
        exp_lec = 0;
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = '0;
            strb_q.push_back({1'b1, AW'(i), 8'h00});
        end
        rst = 1'b0;
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_cnt_esc", {24'd0, cnt_esc}, 32'd0);
        check("rst_cnt_lec", {24'd0, cnt_lec}, 32'd0);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        n = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        check("sweep_len", n, DEPTH);
        check("sweep_strobes_left", strb_q.size(), 0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) fail("ready_timeout");
    endtask

    task automatic send_write(input logic [AW-1:0] dir, input logic [DW-1:0] dat);
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_dir   = dir;
        cmd_dato  = dat;
        wait_ready();
        strb_q.push_back({1'b1, dir, dat});
        ref_mem[dir] = dat;
        exp_esc++;
        tick();
        cmd_valid = 1'b0;
        check("wr_busy", {31'd0, cmd_ready}, 32'd0);
        tick();
        check("wr_ready_again", {31'd0, cmd_ready}, 32'd1);
        check("cnt_esc", {24'd0, cnt_esc}, exp_esc % 256);
    endtask

    task automatic send_read(input logic [AW-1:0] dir, input int hold, input bit abort);
        logic [DW-1:0] e;
        int n;
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_dir   = dir;
        cmd_dato  = DW'($urandom);
        wait_ready();
        strb_q.push_back({1'b0, dir, cmd_dato});
        e = ref_mem[dir];
        resp_q.push_back(e);
        tick();
        cmd_valid = 1'b0;
        check("rd_lat_issue", {31'd0, resp_valid}, 32'd0);
        tick();
        check("rd_lat_capture", {31'd0, resp_valid}, 32'd0);
        tick();
        check("rd_lat_resp", {31'd0, resp_valid}, 32'd1);
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", {31'd0, resp_valid}, 32'd1);
            check("hold_dato", {24'd0, resp_dato}, {24'd0, e});
            check("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            check("hold_br_en", {31'd0, br_en}, 32'd0);
            check("hold_ocupado", {31'd0, ocupado}, 32'd1);
            tick();
        end
        if (abort) return;
        n = 0;
        while (resp_valid && n < 40) begin
            resp_ready = (n >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        resp_ready = 1'b0;
        if (n >= 40) fail("resp_timeout");
        check("rd_ready_after", {31'd0, cmd_ready}, 32'd1);
        check("cnt_lec", {24'd0, cnt_lec}, exp_lec % 256);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_we     = 1'b0;
        cmd_dir    = '0;
        cmd_dato   = '0;
        resp_ready = 1'b0;
        tick();
        do_reset();

        send_write(2'd2, 8'hA5);
        send_read(2'd2, 0, 1'b0);
        send_read(2'd1, 5, 1'b0);      // cleared by the sweep, stalled response

        send_write(2'd3, 8'h5A);
        send_read(2'd3, 5, 1'b1);      // abandon in RESP, reset mid-response
        do_reset();
        check("post_rst_resp_valid", {31'd0, resp_valid}, 32'd0);

        for (int i = 0; i < 256; i++) send_write(AW'($urandom), DW'($urandom));
        check("cnt_esc_wrap", {24'd0, cnt_esc}, exp_esc % 256);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 1) == 1) send_write(AW'($urandom), DW'($urandom));
            else send_read(AW'($urandom), 0, 1'b0);
        end
        check("final_cnt_lec", {24'd0, cnt_lec}, exp_lec % 256);
        check("resp_q_empty", resp_q.size(), 0);
        check("strb_q_empty", strb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
